serial_comparator: RTL and testbench

//  Multi-cycle signed/unsigned magnitude comparator for SIZE-bit operands.
//  - Processes operands MSB-first, DIGIT bits per clock.
//  - Selects signed or unsigned mode per transaction.
//  - Returns greater/equal/less flags over a valid/ready handshake.
//  - Sits between the ALU operand registers and the flag/result stage.
//  - Trades latency for a narrow DIGIT-wide compare datapath.

---
 rtl/serial_comparator_if.sv | 26 ++
 rtl/serial_comparator.sv | 143 ++++++++++++++
 tb/tb_serial_comparator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_if.sv
// Handshake bundle between the ALU operand registers (master) and the serial comparator (slave).
// Carries the operands, the signed-mode select and the greater/equal/less result flags.
interface serial_comparator_if #(
    parameter int SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            is_signed;
    logic            out_valid;
    logic            out_ready;
    logic            is_a_greater;
    logic            equal;
    logic            is_a_less;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, is_a_greater, equal, is_a_less
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, is_a_greater, equal, is_a_less
    );
endinterface

// File: rtl/serial_comparator.sv
// Serial MSB-first magnitude comparator, DIGIT bits per clock, signed or unsigned per transaction.
// Optional SERIAL_COMPARATOR_EARLY_EXIT_EN: finish on the first unequal digit instead of after all digits.
module serial_comparator #(
    parameter int SIZE  = 8,
    parameter int DIGIT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_comparator_if.slave  bus
);
    localparam int NUM_DIGITS = SIZE / DIGIT;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIZE-1:0]  a_q, a_d;
    logic [SIZE-1:0]  b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             out_valid_q, out_valid_d;
    logic             greater_q, greater_d;
    logic             equal_q, equal_d;
    logic             less_q, less_d;

    logic [SIZE-1:0]  sign_flip;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_gt;
    logic             dig_lt;
    logic             last_digit;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = {bus.is_signed, {(SIZE-1){1'b0}}};

    // Operands shift left each BUSY cycle so the current digit is always at the top.
    assign dig_a  = a_q[SIZE-1 -: DIGIT];
    assign dig_b  = b_q[SIZE-1 -: DIGIT];
    assign dig_gt = (dig_a > dig_b);
    assign dig_lt = (dig_a < dig_b);

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    // No earlier digit can have differed, or BUSY would already have been left.
    assign last_digit = (idx_q == LAST_IDX) || dig_gt || dig_lt;
`else
    assign last_digit = (idx_q == LAST_IDX);
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        out_valid_d = out_valid_q;
        greater_d   = greater_q;
        equal_d     = equal_q;
        less_d      = less_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a ^ sign_flip;
                    b_d     = bus.b ^ sign_flip;
                    idx_d   = '0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                gt_d = gt_q | (~gt_q & ~lt_q & dig_gt);
                lt_d = lt_q | (~gt_q & ~lt_q & dig_lt);
                a_d  = a_q << DIGIT;
                b_d  = b_q << DIGIT;
                if (last_digit) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    greater_d   = gt_d;
                    less_d      = lt_d;
                    equal_d     = ~gt_d & ~lt_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    greater_d   = 1'b0;
                    equal_d     = 1'b0;
                    less_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                greater_d   = 1'b0;
                equal_d     = 1'b0;
                less_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            greater_q   <= 1'b0;
            equal_q     <= 1'b0;
            less_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            out_valid_q <= out_valid_d;
            greater_q   <= greater_d;
            equal_q     <= equal_d;
            less_q      <= less_d;
        end
    end

    assign bus.in_ready     = rst_n && (state_q == IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.is_a_greater = greater_q;
    assign bus.equal        = equal_q;
    assign bus.is_a_less    = less_q;
endmodule

// File: tb/tb_serial_comparator.sv
// Directed and random checks of serial_comparator (SIZE=8, DIGIT=2).
// Expected latencies follow SERIAL_COMPARATOR_EARLY_EXIT_EN when it is defined.
module tb_serial_comparator;
    localparam int SIZE  = 8;
    localparam int DIGIT = 2;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 4;
`endif
    localparam int LAT_FULL = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_comparator_if #(.SIZE(SIZE)) bus ();

    serial_comparator #(.SIZE(SIZE), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [2:0] flags_w;
    assign flags_w = {bus.is_a_greater, bus.equal, bus.is_a_less};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s timeout waiting on DUT", tag);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) timeout_fail({tag, "_in_ready"});
    endtask

    // Accept edge is k; lat counts edges after k until out_valid is seen.
    task automatic start_wait(input string tag, input logic [7:0] av, input logic [7:0] bv,
                              input logic sg, output int lat);
        wait_ready(tag);
        bus.a         = av;
        bus.b         = bv;
        bus.is_signed = sg;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) timeout_fail({tag, "_out_valid"});
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_drop_flags"}, 32'(flags_w), 32'd0);
    endtask

    task automatic cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic sg, input logic [2:0] exp_f, input int exp_lat);
        int lat;
        start_wait(tag, av, bv, sg, lat);
        $display("[TB] %s a=%02h b=%02h signed=%0d flags=%03b latency=%0d", tag, av, bv, sg, flags_w, lat);
        check({tag, "_flags"}, 32'(flags_w), 32'(exp_f));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        release_result(tag);
    endtask

    initial begin
        int lat;
        logic [7:0] av, bv;
        logic sg;
        logic [2:0] exp_f;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_flags", 32'(flags_w), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        cmp("t1_unsigned_gt", 8'hC8, 8'h37, 1'b0, 3'b100, LAT_EARLY);
        cmp("t2_signed_lt",   8'h80, 8'h7F, 1'b1, 3'b001, LAT_EARLY);
        cmp("t2_unsigned_gt", 8'h80, 8'h7F, 1'b0, 3'b100, LAT_EARLY);
        cmp("t3_signed_gt",   8'hFF, 8'hFE, 1'b1, 3'b100, LAT_FULL);
        cmp("t3_equal",       8'hA5, 8'hA5, 1'b1, 3'b010, LAT_FULL);

        // Back-pressure: result held in DONE, a stray in_valid must not be accepted.
        start_wait("t4", 8'h12, 8'h34, 1'b0, lat);
        check("t4_flags", 32'(flags_w), 32'(3'b001));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            bus.a        = 8'hFF;
            bus.b        = 8'h00;
            @(posedge clk); #1;
            $display("[TB] t4 hold cycle %0d flags=%03b in_ready=%0d out_valid=%0d", i, flags_w, bus.in_ready, bus.out_valid);
            check("t4_hold_flags", 32'(flags_w), 32'(3'b001));
            check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("t4_hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        release_result("t4");
        check("t4_idle_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("t4_no_accept", 32'(bus.out_valid), 32'd0);

        // Reset asserted during the second BUSY cycle.
        wait_ready("t5");
        bus.a         = 8'hF0;
        bus.b         = 8'h0F;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("[TB] t5 reset mid-op out_valid=%0d flags=%03b in_ready=%0d", bus.out_valid, flags_w, bus.in_ready);
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_flags", 32'(flags_w), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("t5_release_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t5_discarded", 32'(bus.out_valid), 32'd0);
        cmp("t5_after_lt", 8'h01, 8'h02, 1'b0, 3'b001, LAT_FULL);

        // Random pairs in both modes against the language's own compare.
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = (n % 8 == 0) ? av : 8'($urandom);
            sg = 1'($urandom);
            if (sg) exp_f = {$signed(av) > $signed(bv), av == bv, $signed(av) < $signed(bv)};
            else    exp_f = {av > bv, av == bv, av < bv};
            start_wait("t6", av, bv, sg, lat);
            $display("[TB] t6 #%0d a=%02h b=%02h signed=%0d flags=%03b exp=%03b", n, av, bv, sg, flags_w, exp_f);
            check("t6_flags", 32'(flags_w), 32'(exp_f));
            check("t6_onehot", 32'($countones(flags_w)), 32'd1);
            release_result("t6");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
